// File: rtl/sext_share_arbiter.sv
// ---------------------------------------------------------------------------
// sext_share_arbiter
//
// Shares a single IN_W -> OUT_W extension datapath among NREQ byte
// producers.  Each cycle a round-robin arbiter picks one valid requester,
// extends its byte and loads the result into a one-entry output register
// that is drained through a valid/ready handshake.  A new result may
// replace the register in the same cycle the old one is taken, so a
// continuously requesting set of sources sees one grant per cycle.
//
// Build option:
//   SEXT_ZEXT_MODE_EN  when defined, req_zext[i]=1 selects zero extension
//                      for requester i; when undefined req_zext is ignored
//                      and every result is sign-extended.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NREQ]       per-requester request valid
//   req_data   in   [NREQ*IN_W]  requester i byte at [i*IN_W +: IN_W]
//   req_zext   in   [NREQ]       per-requester zero-extend select
//   req_ready  out  [NREQ]       one-hot grant (combinational)
//   out_valid  out               output register holds a result
//   out_data   out  [OUT_W]      extended result
//   out_id     out  [IDW]        requester index that produced out_data
//   out_ready  in                downstream accepts the output
// ---------------------------------------------------------------------------
module sext_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 8,
   parameter int OUT_W = 32,
   parameter int IDW   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*IN_W-1:0]   req_data,
   input  logic [NREQ-1:0]        req_zext,
   output logic [NREQ-1:0]        req_ready,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   output logic [IDW-1:0]         out_id,
   input  logic                   out_ready
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [OUT_W-1:0]     out_data_q, out_data_d;
   logic [IDW-1:0]       out_id_q, out_id_d;
   logic [IDW-1:0]       last_gnt_q, last_gnt_d;

   logic                 found;
   logic [IDW-1:0]       winner;
   logic                 can_accept;
   logic                 grant;
   logic [IN_W-1:0]      sel_byte;
   logic                 sel_zext;
   logic [OUT_W-1:0]     ext_result;

   // Replicate the fill bit (sign bit, or 0 for zero extension) above the
   // unchanged input byte.
   function automatic logic [OUT_W-1:0] ext_byte(input logic [IN_W-1:0] b,
                                                 input logic           zext);
      logic fill;
      fill = zext ? 1'b0 : b[IN_W-1];
      return {{(OUT_W-IN_W){fill}}, b};
   endfunction

   // Round-robin search: start one past the last winner and wrap upward.
   // Bits are extracted by shifting so that no variable-index select is
   // needed on the request vectors.
   always_comb begin
      logic [NREQ-1:0] shifted;
      int              idx;
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx     = (int'(last_gnt_q) + k) % NREQ;
         shifted = req_valid >> idx;
         if (!found && shifted[0]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   // Selected requester's byte and extension mode.
   always_comb begin
      logic [NREQ*IN_W-1:0] data_shift;
      data_shift = req_data >> (int'(winner) * IN_W);
      sel_byte   = data_shift[IN_W-1:0];
   end

`ifdef SEXT_ZEXT_MODE_EN
   always_comb begin
      logic [NREQ-1:0] zext_shift;
      zext_shift = req_zext >> winner;
      sel_zext   = zext_shift[0];
   end
`else
   // The port is kept for a uniform interface; its value has no effect.
   logic zext_unused;
   assign zext_unused = ^req_zext;
   assign sel_zext    = 1'b0;
`endif

   assign ext_result = ext_byte(sel_byte, sel_zext);

   // Next-state and outputs.  Grants are suppressed while reset is high so
   // the upstream never sees a handshake that the register will discard.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      last_gnt_d = last_gnt_q;
      req_ready  = '0;
      out_valid  = (state_q == ST_FULL);

      can_accept = (state_q == ST_EMPTY) || out_ready;
      grant      = found && can_accept && !reset;

      if (grant) begin
         req_ready  = NREQ'(1) << winner;
         state_d    = ST_FULL;
         out_data_d = ext_result;
         out_id_d   = winner;
         last_gnt_d = winner;
      end else if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         out_id_q   <= '0;
         last_gnt_q <= IDW'(NREQ - 1);
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   assign out_data = out_data_q;
   assign out_id   = out_id_q;

endmodule

// File: tb/tb_sext_share_arbiter.sv
module tb_sext_share_arbiter;

   localparam int NREQ  = 4;
   localparam int IN_W  = 8;
   localparam int OUT_W = 32;
   localparam int IDW   = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      req_zext;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic [OUT_W-1:0]     out_data;
   logic [IDW-1:0]       out_id;
   logic                 out_ready;

   typedef struct {
      logic [IDW-1:0]   id;
      logic [OUT_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done     = 1'b0;

   sext_share_arbiter #(
      .NREQ (NREQ),
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .IDW  (IDW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_zext (req_zext),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_id   (out_id),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [IDW-1:0] id, input logic [OUT_W-1:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expected entry for every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!done && !reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_output", {30'd0, out_id}, 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               check("sb_out_id", {30'd0, out_id}, {30'd0, e.id});
               check("sb_out_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_zext  = '0;
      req_data  = {8'hFF, 8'h80, 8'h7F, 8'h80};
      out_ready = 1'b1;

      // Reset: req_ready must stay low even with requests pending.
      tick();
      req_valid = 4'b1111;
      tick();
      #1;
      check("rst_req_ready", {28'd0, req_ready}, 32'h0);
      check("rst_out_valid", {31'd0, out_valid}, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_id", {30'd0, out_id}, 32'h0);

      // Single requester, negative byte.
      reset     = 1'b0;
      req_valid = 4'b0001;
      #1;
      check("t1_req_ready", {28'd0, req_ready}, 32'h1);
      push(2'd0, 32'hFFFF_FF80);
      tick();
      req_valid = 4'b0000;
      #1;
      check("t1_out_valid", {31'd0, out_valid}, 32'h1);
      tick();
      check("t1_empty", {31'd0, out_valid}, 32'h0);

      // Re-reset so requester 0 has top priority again.
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // All four requesters continuously valid: fair rotation.
      req_data  = {8'hFF, 8'h80, 8'h7F, 8'h01};
      req_valid = 4'b1111;
      push(2'd0, 32'h0000_0001);
      push(2'd1, 32'h0000_007F);
      push(2'd2, 32'hFFFF_FF80);
      push(2'd3, 32'hFFFF_FFFF);
      push(2'd0, 32'h0000_0001);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_req_ready", {28'd0, req_ready}, 32'h1 << (k % 4));
         tick();
      end

      // Load id1, then stall for three cycles.
      push(2'd1, 32'h0000_007F);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall_req_ready", {28'd0, req_ready}, 32'h0);
         check("stall_out_id", {30'd0, out_id}, 32'h1);
         check("stall_out_data", out_data, 32'h0000_007F);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("unstall_req_ready", {28'd0, req_ready}, 32'h4);
      push(2'd2, 32'hFFFF_FF80);
      tick();

      // Second grant (id3) held in the register, then discarded by reset.
      #1;
      check("hold_req_ready", {28'd0, req_ready}, 32'h8);
      push(2'd3, 32'hFFFF_FFFF);
      tick();
      out_ready = 1'b0;
      reset     = 1'b1;
      void'(exp_q.pop_back());
      #1;
      check("rst2_req_ready", {28'd0, req_ready}, 32'h0);
      tick();
      check("rst2_out_valid", {31'd0, out_valid}, 32'h0);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst2_first_grant", {28'd0, req_ready}, 32'h1);
      push(2'd0, 32'h0000_0001);
      tick();
      req_valid = 4'b0000;
      tick();

      // Zero-extend select on requester 2.
      req_data  = {8'hFF, 8'h80, 8'h7F, 8'h01};
      req_valid = 4'b0100;
      req_zext  = 4'b0100;
      #1;
      check("zx_req_ready", {28'd0, req_ready}, 32'h4);
`ifdef SEXT_ZEXT_MODE_EN
      push(2'd2, 32'h0000_0080);
`else
      push(2'd2, 32'hFFFF_FF80);
`endif
      tick();
      req_valid = 4'b0000;
      req_zext  = 4'b0000;
      tick();

      // Intermittent requests: 0100 -> 0000 -> 1000.
      req_valid = 4'b0100;
      #1;
      check("tg_req_ready2", {28'd0, req_ready}, 32'h4);
      push(2'd2, 32'hFFFF_FF80);
      tick();
      req_valid = 4'b0000;
      #1;
      check("tg_idle_ready", {28'd0, req_ready}, 32'h0);
      tick();
      req_valid = 4'b1000;
      #1;
      check("tg_after_idle_valid", {31'd0, out_valid}, 32'h0);
      check("tg_req_ready3", {28'd0, req_ready}, 32'h8);
      push(2'd3, 32'hFFFF_FFFF);
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      @(negedge clk);
      #1;
      done = 1'b1;
      check("sb_drained", exp_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
